// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter
//   Shares one synchronous character-font ROM between the display pixel path
//   (fixed priority, fixed ROM_LAT latency) and a background host requester
//   (request / ack / valid handshake, served in idle ROM cycles).
//
// Ports
//   clk, reset             : clock, asynchronous active-high reset
//   disp_req, disp_addr    : display lookup this cycle
//   disp_data, disp_valid  : font word for the display, ROM_LAT cycles later
//   disp_miss              : a display lookup was dropped by the starvation guard
//   host_req, host_addr    : host lookup request (sampled in IDLE only)
//   host_ack               : one-cycle pulse, request accepted
//   host_data, host_valid  : registered host result and its update pulse
//   rom_addr, rom_data     : font ROM address out / data in
//   busy                   : host transaction in progress
//
// Build option
//   FONT_ARB_STARVE_GUARD_EN : when defined, a host that has waited STARVE_MAX
//   PEND cycles pre-empts the display for one cycle (flagged by disp_miss).
module font_rom_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_miss,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_data,
  output logic              host_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT, S_DONE} state_t;

  // One entry per ROM cycle: was the ROM read, was it for the host, and was a
  // display lookup pre-empted in that cycle.
  typedef struct packed {
    logic valid;
    logic host;
    logic miss;
  } tag_t;

  localparam int WCNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   host_addr_q, host_addr_d;
  logic [DATA_W-1:0]   host_data_q, host_data_d;
  logic                first_pend_q, first_pend_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  tag_t                tag_q [ROM_LAT];
  tag_t                tag_push;
  tag_t                tag_head;
  logic                host_issue;
  logic                disp_win;
  logic                starve_ovr;

`ifdef FONT_ARB_STARVE_GUARD_EN
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);
  logic [SCNT_W-1:0] starve_cnt_q;

  // Counts PEND cycles spent without an issue; it only leaves zero while
  // pending and is cleared by the issue that ends PEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else if (host_issue) begin
      starve_cnt_q <= '0;
    end else if (state_q == S_PEND && starve_cnt_q != SCNT_W'(STARVE_MAX)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  assign starve_ovr = (state_q == S_PEND) && disp_req &&
                      (starve_cnt_q == SCNT_W'(STARVE_MAX));
`else
  assign starve_ovr = 1'b0;
`endif

  assign host_issue = (state_q == S_PEND) && (!disp_req || starve_ovr);
  assign disp_win   = disp_req && !starve_ovr;

  always_comb begin
    rom_addr = '0;
    if (disp_win) begin
      rom_addr = disp_addr;
    end else if (host_issue) begin
      rom_addr = host_addr_q;
    end
  end

  assign tag_push.valid = disp_win || host_issue;
  assign tag_push.host  = host_issue;
  assign tag_push.miss  = starve_ovr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_push;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_head   = tag_q[ROM_LAT-1];
  assign disp_valid = tag_head.valid && !tag_head.host;
  assign disp_data  = disp_valid ? rom_data : '0;
  // The miss bit can only be set by an override, so without the guard this
  // output is constant zero.
  assign disp_miss  = tag_head.miss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      host_addr_q  <= '0;
      host_data_q  <= '0;
      first_pend_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      host_addr_q  <= host_addr_d;
      host_data_q  <= host_data_d;
      first_pend_q <= first_pend_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    host_addr_d  = host_addr_q;
    host_data_d  = host_data_q;
    first_pend_d = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (host_req) begin
          host_addr_d  = host_addr;
          first_pend_d = 1'b1;
          state_d      = S_PEND;
        end
      end
      S_PEND: begin
        if (host_issue) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // The ROM word for the host read appears in the last WAIT cycle.
        if (wait_cnt_q == WCNT_W'(ROM_LAT - 1)) begin
          host_data_d = rom_data;
          state_d     = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign host_ack   = (state_q == S_PEND) && first_pend_q;
  assign host_valid = (state_q == S_DONE);
  assign host_data  = host_data_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_font_rom_arbiter.sv
module tb_font_rom_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 8;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        disp_req;
  logic [10:0] disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        disp_miss;
  logic        host_req;
  logic [10:0] host_addr;
  logic        host_ack;
  logic [7:0]  host_data;
  logic        host_valid;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        busy;

  font_rom_arbiter #(
    .ADDR_W(11), .DATA_W(8), .ROM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .disp_miss(disp_miss),
    .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack),
    .host_data(host_data), .host_valid(host_valid),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  // Font ROM contents: a fixed scramble of the address.
  function automatic logic [7:0] romf(input logic [10:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd37 + 16'd11;
    return t[7:0] ^ {a[10:8], a[4:0]};
  endfunction

  // Behavioural synchronous ROM with LAT cycles of latency.
  logic [10:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign rom_data = romf(apipe[LAT-1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard queues, filled by the stimulus side, drained by the monitor.
  exp_t        disp_q [$];
  exp_t        host_q [$];
  int          ack_q  [$];
  int          miss_q [$];
  logic [7:0]  exp_hd = '0;
  logic [10:0] exp_rom_addr = '0;
  logic        exp_busy = 1'b0;

  // Reference model of the host side, kept as timestamps.
  logic        m_pend = 1'b0;
  int          m_pend_start = 0;
  int          m_idle_from = 0;
  logic [10:0] m_addr = '0;

  int last_hv_cyc   = -1;
  int prev_hv_cyc   = -1;
  int last_ack_cyc  = -1;
  int last_miss_cyc = -1;
  int disp_cnt      = 0;
  int miss_cnt      = 0;

  always @(negedge clk) begin
    if (reset) begin
      disp_q.delete(); host_q.delete(); ack_q.delete(); miss_q.delete();
      exp_hd = '0;
    end
    if (disp_valid === 1'b1) disp_cnt++;
    if (disp_miss === 1'b1) begin miss_cnt++; last_miss_cyc = cyc; end
    if (host_ack === 1'b1) last_ack_cyc = cyc;
    if (host_valid === 1'b1) begin prev_hv_cyc = last_hv_cyc; last_hv_cyc = cyc; end

    if (disp_q.size() != 0 && disp_q[0].cyc == cyc) begin
      check("disp_valid", 32'(disp_valid), 1);
      check("disp_data", 32'(disp_data), 32'(disp_q[0].data));
      void'(disp_q.pop_front());
    end else begin
      check("disp_quiet", 32'({disp_valid, disp_data}), 0);
    end

    if (miss_q.size() != 0 && miss_q[0] == cyc) begin
      check("disp_miss", 32'(disp_miss), 1);
      void'(miss_q.pop_front());
    end else begin
      check("disp_miss_quiet", 32'(disp_miss), 0);
    end

    if (ack_q.size() != 0 && ack_q[0] == cyc) begin
      check("host_ack", 32'(host_ack), 1);
      void'(ack_q.pop_front());
    end else begin
      check("host_ack_quiet", 32'(host_ack), 0);
    end

    if (host_q.size() != 0 && host_q[0].cyc == cyc) begin
      check("host_valid", 32'(host_valid), 1);
      exp_hd = host_q[0].data;
      void'(host_q.pop_front());
    end else begin
      check("host_valid_quiet", 32'(host_valid), 0);
    end
    check("host_data", 32'(host_data), 32'(exp_hd));
    check("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
    check("busy", 32'(busy), 32'(exp_busy));
  end

  // Drive one cycle of inputs and advance the reference model.
  task automatic drive(input logic dr, input logic [10:0] da,
                       input logic hr, input logic [10:0] ha, output int c);
    logic issue;
    logic ovr;
    @(posedge clk);
    #1;
    c = cyc;
    disp_req = dr; disp_addr = da; host_req = hr; host_addr = ha;
    exp_busy = m_pend || (c < m_idle_from);
    issue = 1'b0;
    ovr   = 1'b0;
    if (m_pend) begin
      if (!dr) issue = 1'b1;
`ifdef FONT_ARB_STARVE_GUARD_EN
      else if (c - m_pend_start >= SMAX) begin issue = 1'b1; ovr = 1'b1; end
`endif
    end
    if (dr && !ovr) begin
      disp_q.push_back('{c + LAT, romf(da)});
      exp_rom_addr = da;
    end else if (issue) begin
      exp_rom_addr = m_addr;
    end else begin
      exp_rom_addr = '0;
    end
    if (ovr) miss_q.push_back(c + LAT);
    if (issue) begin
      host_q.push_back('{c + LAT + 1, romf(m_addr)});
      m_pend      = 1'b0;
      m_idle_from = c + LAT + 2;
    end else if (!m_pend && c >= m_idle_from && hr) begin
      m_pend       = 1'b1;
      m_pend_start = c + 1;
      m_addr       = ha;
      ack_q.push_back(c + 1);
    end
  endtask

  task automatic idle(input int n);
    int c;
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, c);
  endtask

  initial begin
    int c, c0, saved, base;
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0; host_req = 1'b0; host_addr = '0;
    #3;
    check("rst_outputs", 32'({host_ack, host_valid, disp_valid, disp_miss, busy}), 0);
    check("rst_host_data", 32'(host_data), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Host only.
    drive(1'b0, '0, 1'b1, 11'h2A3, c0);
    idle(LAT + 4);
    check("host_only_ack_lat", 32'(last_ack_cyc - c0), 1);
    check("host_only_valid_lat", 32'(last_hv_cyc - c0), 32'(2 + LAT));
    check("host_only_data", 32'(host_data), 32'(romf(11'h2A3)));
    idle(3);
    check("host_data_hold", 32'(host_data), 32'(romf(11'h2A3)));

    // Display streaming.
    base = disp_cnt;
    for (int i = 0; i < 100; i++) drive(1'b1, 11'(i), 1'b0, '0, c);
    idle(LAT + 2);
    check("stream_count", 32'(disp_cnt - base), 100);

    // Contention: six display cycles delay the host by six cycles.
    drive(1'b0, '0, 1'b1, 11'h123, c0);
    for (int i = 0; i < 6; i++) drive(1'b1, 11'($urandom), 1'b0, '0, c);
    idle(LAT + 4);
    check("contention_valid_lat", 32'(last_hv_cyc - c0), 32'(8 + LAT));

    // Back-to-back host requests.
    for (int i = 0; i < 3 * (3 + LAT); i++) drive(1'b0, '0, 1'b1, 11'(100 + i), c);
    idle(LAT + 4);
    check("b2b_period", 32'(last_hv_cyc - prev_hv_cyc), 32'(3 + LAT));

    // Asynchronous reset in the middle of WAIT with a display word in flight.
    drive(1'b1, 11'h055, 1'b1, 11'h1F0, c0);
    drive(1'b0, '0, 1'b0, '0, c);
    drive(1'b0, '0, 1'b0, '0, c);
    drive(1'b0, '0, 1'b0, '0, c);
    check("pre_reset_busy", 32'(busy), 1);
    check("pre_reset_disp_valid", 32'(disp_valid), 1);
    saved = last_hv_cyc;
    #2;
    reset = 1'b1;
    disp_req = 1'b0; host_req = 1'b0;
    m_pend = 1'b0; m_idle_from = 0; exp_busy = 1'b0; exp_rom_addr = '0;
    #1;
    check("mid_reset_flags", 32'({host_ack, host_valid, disp_valid, disp_miss, busy}), 0);
    check("mid_reset_data", 32'({host_data, disp_data}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(LAT + 4);
    check("no_hv_after_reset", 32'(last_hv_cyc), 32'(saved));

    // Display held high while the host waits.
    base = miss_cnt;
    drive(1'b0, '0, 1'b1, 11'h3C7, c0);
    for (int i = 0; i < 3 * SMAX; i++) drive(1'b1, 11'($urandom), 1'b0, '0, c);
`ifdef FONT_ARB_STARVE_GUARD_EN
    check("guard_miss_cyc", 32'(last_miss_cyc - c0), 32'(1 + SMAX + LAT));
    check("guard_valid_cyc", 32'(last_hv_cyc - c0), 32'(2 + SMAX + LAT));
`else
    check("noguard_still_pend", 32'(busy), 1);
    check("noguard_no_miss", 32'(miss_cnt - base), 0);
`endif
    idle(LAT + 4);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 11'($urandom),
            1'($urandom_range(0, 9) < 2), 11'($urandom), c);
    end
    idle(LAT + 8);
    check("drain_disp", 32'(disp_q.size()), 0);
    check("drain_host", 32'(host_q.size()), 0);
    check("drain_ack", 32'(ack_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
